// File: rtl/wb_classic_initiator_if.sv
// Command/response handshake and Wishbone-classic bus bundle for wb_classic_initiator.
// The master modport is the initiator's view; slave is the bench/host side.
interface wb_classic_initiator_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_we;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  cyc_o;
    logic                  stb_o;
    logic                  we_o;
    logic [ADDR_WIDTH-1:0] addr_o;
    logic [DATA_WIDTH-1:0] data_o;
    logic [DATA_WIDTH-1:0] data_i;
    logic                  ack_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, data_i, ack_i,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output cyc_o, stb_o, we_o, addr_o, data_o
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, data_i, ack_i,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  cyc_o, stb_o, we_o, addr_o, data_o
    );
endinterface

// File: rtl/wb_classic_initiator.sv
// Wishbone-classic initiator: one bus cycle per command, result on a response port.
// Define WB_TIMEOUT_EN to abort cycles whose ack never arrives (TIMEOUT_CYCLES).
module wb_classic_initiator #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    wb_classic_initiator_if.master bus,
    output logic                   busy
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t                state, state_n;
    logic                  cmd_ready_q, cmd_ready_n;
    logic                  rsp_valid_q, rsp_valid_n;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_n;
    logic                  rsp_err_q, rsp_err_n;
    logic                  cyc_q, cyc_n;
    logic                  stb_q, stb_n;
    logic                  we_q, we_n;
    logic [ADDR_WIDTH-1:0] addr_q, addr_n;
    logic [DATA_WIDTH-1:0] data_q, data_n;
    logic                  busy_q, busy_n;

`ifdef WB_TIMEOUT_EN
    localparam int CLOG_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W  = (CLOG_W > 8) ? CLOG_W : 8;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_n, cnt_inc;
    logic             expire;

    // Expires on the wait cycle that brings the waited count up to the limit.
    assign cnt_inc = cnt_q + 1'b1;
    assign expire  = (cnt_inc == LIMIT);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            busy_q      <= 1'b0;
`ifdef WB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state       <= state_n;
            cmd_ready_q <= cmd_ready_n;
            rsp_valid_q <= rsp_valid_n;
            rsp_rdata_q <= rsp_rdata_n;
            rsp_err_q   <= rsp_err_n;
            cyc_q       <= cyc_n;
            stb_q       <= stb_n;
            we_q        <= we_n;
            addr_q      <= addr_n;
            data_q      <= data_n;
            busy_q      <= busy_n;
`ifdef WB_TIMEOUT_EN
            cnt_q       <= cnt_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        cmd_ready_n = cmd_ready_q;
        rsp_valid_n = rsp_valid_q;
        rsp_rdata_n = rsp_rdata_q;
        rsp_err_n   = rsp_err_q;
        cyc_n       = cyc_q;
        stb_n       = stb_q;
        we_n        = we_q;
        addr_n      = addr_q;
        data_n      = data_q;
        busy_n      = busy_q;
`ifdef WB_TIMEOUT_EN
        cnt_n       = cnt_q;
`endif
        unique case (state)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    cmd_ready_n = 1'b0;
                    busy_n      = 1'b1;
                    if (bus.cmd_addr[1:0] == 2'b00) begin
                        we_n    = bus.cmd_we;
                        addr_n  = bus.cmd_addr;
                        data_n  = bus.cmd_wdata;
                        cyc_n   = 1'b1;
                        stb_n   = 1'b1;
                        state_n = BUS;
`ifdef WB_TIMEOUT_EN
                        cnt_n   = '0;
`endif
                    end else begin
                        rsp_valid_n = 1'b1;
                        rsp_err_n   = 1'b1;
                        rsp_rdata_n = '0;
                        state_n     = RESP;
                    end
                end
            end
            BUS: begin
                if (bus.ack_i) begin
                    cyc_n       = 1'b0;
                    stb_n       = 1'b0;
                    we_n        = 1'b0;
                    rsp_rdata_n = we_q ? '0 : bus.data_i;
                    rsp_err_n   = 1'b0;
                    rsp_valid_n = 1'b1;
                    state_n     = RESP;
                end
`ifdef WB_TIMEOUT_EN
                else if (expire) begin
                    cyc_n       = 1'b0;
                    stb_n       = 1'b0;
                    we_n        = 1'b0;
                    rsp_rdata_n = '0;
                    rsp_err_n   = 1'b1;
                    rsp_valid_n = 1'b1;
                    state_n     = RESP;
                end else begin
                    cnt_n = cnt_inc;
                end
`endif
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    cmd_ready_n = 1'b1;
                    busy_n      = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.cyc_o     = cyc_q;
    assign bus.stb_o     = stb_q;
    assign bus.we_o      = we_q;
    assign bus.addr_o    = addr_q;
    assign bus.data_o    = data_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_wb_classic_initiator.sv
// Bench for wb_classic_initiator: table vectors, corner sequences and random traffic.
// A registered memory responder with programmable ack delay sits on the bus.
module tb_wb_classic_initiator;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    always #5 clk = ~clk;

    wb_classic_initiator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    wb_classic_initiator #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .busy(busy)
    );

    // Responder memory (bus side) and reference memory (model side)
    logic [31:0] rmem    [64] = '{default: '0};
    logic [31:0] ref_mem [64] = '{default: '0};
    logic        r_ack   = 1'b0;
    logic        stray   = 1'b0;
    logic [31:0] r_data  = '0;
    int          r_cnt   = 0;
    int          ack_delay = 0;
    bit          ack_en  = 1'b1;

    assign bus.ack_i  = r_ack | stray;
    assign bus.data_i = r_data;

    always @(posedge clk) begin
        if (rst || !(bus.cyc_o && bus.stb_o)) begin
            r_ack <= 1'b0;
            r_cnt <= 0;
        end else if (r_ack) begin
            r_ack <= 1'b0;
            r_cnt <= 0;
        end else if (ack_en && r_cnt == ack_delay) begin
            r_ack <= 1'b1;
            if (bus.we_o) rmem[bus.addr_o[7:2]] <= bus.data_o;
            else          r_data <= rmem[bus.addr_o[7:2]];
        end else begin
            r_cnt <= r_cnt + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic accept(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = we;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic release_rsp();
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int dly, input int hold,
                          output logic [31:0] rdata, output logic err,
                          output logic saw_cyc, output logic saw_we, output logic ok);
        int n;
        ack_delay = dly;
        saw_cyc = 1'b0;
        saw_we  = 1'b0;
        rdata   = '0;
        err     = 1'b0;
        accept(we, addr, wdata);
        n = 0;
        while (!bus.rsp_valid && n < 200) begin
            @(negedge clk);
            if (bus.cyc_o) begin
                saw_cyc = 1'b1;
                saw_we  = bus.we_o;
            end
            n++;
        end
        ok = bus.rsp_valid;
        if (!ok) return;
        repeat (hold) @(negedge clk);
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          dly;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vt [11];

    initial begin
        logic [31:0] rd, a;
        logic        er, sc, sw, ok, w;
        int          n, idx, lo;

        vt[0]  = '{1'b1, 32'h10, 32'hDEADBEEF, 0, 32'h0,        1'b0};
        vt[1]  = '{1'b0, 32'h10, 32'h0,        1, 32'hDEADBEEF, 1'b0};
        vt[2]  = '{1'b0, 32'h13, 32'h0,        0, 32'h0,        1'b1};
        vt[3]  = '{1'b1, 32'h20, 32'h12345678, 2, 32'h0,        1'b0};
        vt[4]  = '{1'b0, 32'h20, 32'h0,        0, 32'h12345678, 1'b0};
        vt[5]  = '{1'b1, 32'h21, 32'hAAAA5555, 0, 32'h0,        1'b1};
        vt[6]  = '{1'b0, 32'h20, 32'h0,        2, 32'h12345678, 1'b0};
        vt[7]  = '{1'b0, 32'h00, 32'h0,        1, 32'h0,        1'b0};
        vt[8]  = '{1'b1, 32'h00, 32'hCAFEF00D, 0, 32'h0,        1'b0};
        vt[9]  = '{1'b0, 32'h00, 32'h0,        0, 32'hCAFEF00D, 1'b0};
        vt[10] = '{1'b0, 32'h02, 32'h0,        1, 32'h0,        1'b1};

        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata,      32'd0);
        chk("rst_cyc",       32'(bus.cyc_o),     32'd0);
        chk("rst_stb",       32'(bus.stb_o),     32'd0);
        chk("rst_we",        32'(bus.we_o),      32'd0);
        chk("rst_addr",      bus.addr_o,         32'd0);
        chk("rst_data",      bus.data_o,         32'd0);
        chk("rst_busy",      32'(busy),          32'd0);
        rst = 1'b0;

        // Table vectors
        for (int i = 0; i < 11; i++) begin
            do_txn(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].dly, i % 3, rd, er, sc, sw, ok);
            chk($sformatf("vec%0d_done", i), 32'(ok), 32'd1);
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].exp_err));
            chk($sformatf("vec%0d_cyc", i), 32'(sc), 32'(!vt[i].exp_err));
            if (!vt[i].exp_err) begin
                chk($sformatf("vec%0d_we", i), 32'(sw), 32'(vt[i].we));
                if (vt[i].we) ref_mem[vt[i].addr[7:2]] = vt[i].wdata;
            end
        end

        // Minimum latency on an aligned read
        ack_delay = 0;
        accept(1'b0, 32'h10, 32'h0);
        @(negedge clk);
        chk("lat_cyc_n1",   32'(bus.cyc_o),     32'd1);
        chk("lat_stb_n1",   32'(bus.stb_o),     32'd1);
        chk("lat_ready_n1", 32'(bus.cmd_ready), 32'd0);
        chk("lat_busy_n1",  32'(busy),          32'd1);
        chk("lat_valid_n1", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        chk("lat_valid_n2", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        chk("lat_valid_n3", 32'(bus.rsp_valid), 32'd1);
        chk("lat_rdata",    bus.rsp_rdata,      32'hDEADBEEF);
        chk("lat_cyc_done", 32'(bus.cyc_o),     32'd0);
        release_rsp();
        chk("lat_ready_back", 32'(bus.cmd_ready), 32'd1);

        // Misaligned: response right after acceptance, no bus cycle
        accept(1'b0, 32'h13, 32'h0);
        @(negedge clk);
        chk("mis_valid", 32'(bus.rsp_valid), 32'd1);
        chk("mis_err",   32'(bus.rsp_err),   32'd1);
        chk("mis_rdata", bus.rsp_rdata,      32'd0);
        chk("mis_cyc",   32'(bus.cyc_o),     32'd0);
        release_rsp();

        // Backpressure on the response port
        ack_delay = 0;
        accept(1'b0, 32'h0, 32'h0);
        n = 0;
        while (!bus.rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rdata", bus.rsp_rdata,      ref_mem[0]);
            chk("bp_err",   32'(bus.rsp_err),   32'd0);
            chk("bp_ready", 32'(bus.cmd_ready), 32'd0);
        end
        release_rsp();
        chk("bp_valid_drop", 32'(bus.rsp_valid), 32'd0);
        chk("bp_ready_back", 32'(bus.cmd_ready), 32'd1);
        chk("bp_busy_drop",  32'(busy),          32'd0);

        // Stray ack in IDLE
        @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        @(negedge clk);
        chk("stray_valid", 32'(bus.rsp_valid), 32'd0);
        chk("stray_busy",  32'(busy),          32'd0);
        chk("stray_ready", 32'(bus.cmd_ready), 32'd1);

`ifdef WB_TIMEOUT_EN
        // Ack never arrives: error after 4 waiting cycles
        ack_en = 1'b0;
        accept(1'b0, 32'h10, 32'h0);
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (bus.rsp_valid) break;
            n++;
        end
        chk("to_waits", 32'(n),             32'd4);
        chk("to_valid", 32'(bus.rsp_valid), 32'd1);
        chk("to_err",   32'(bus.rsp_err),   32'd1);
        chk("to_rdata", bus.rsp_rdata,      32'd0);
        chk("to_cyc",   32'(bus.cyc_o),     32'd0);
        release_rsp();
        ack_en = 1'b1;
        // Ack on exactly the 4th waiting cycle wins
        do_txn(1'b0, 32'h10, 32'h0, 2, 0, rd, er, sc, sw, ok);
        chk("to_edge_err",   32'(er), 32'd0);
        chk("to_edge_rdata", rd,      ref_mem[4]);
        // One cycle later is too late
        do_txn(1'b0, 32'h10, 32'h0, 3, 0, rd, er, sc, sw, ok);
        chk("to_late_err",   32'(er), 32'd1);
        chk("to_late_rdata", rd,      32'd0);
`else
        // Ack delayed 7 cycles: bus signals stay stable throughout
        ack_delay = 7;
        accept(1'b0, 32'h20, 32'h0);
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (bus.rsp_valid) break;
            chk("dly_cyc",  32'(bus.cyc_o), 32'd1);
            chk("dly_stb",  32'(bus.stb_o), 32'd1);
            chk("dly_we",   32'(bus.we_o),  32'd0);
            chk("dly_addr", bus.addr_o,     32'h20);
            n++;
        end
        chk("dly_waits", 32'(n),             32'd9);
        chk("dly_valid", 32'(bus.rsp_valid), 32'd1);
        chk("dly_rdata", bus.rsp_rdata,      32'h12345678);
        release_rsp();
`endif

        // Reset while in BUS
        ack_en = 1'b0;
        accept(1'b1, 32'h30, 32'h55AA55AA);
        @(negedge clk);
        @(negedge clk);
        chk("rb_cyc_pre",  32'(bus.cyc_o), 32'd1);
        chk("rb_busy_pre", 32'(busy),      32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ack_en = 1'b1;
        chk("rb_cyc",   32'(bus.cyc_o),     32'd0);
        chk("rb_stb",   32'(bus.stb_o),     32'd0);
        chk("rb_busy",  32'(busy),          32'd0);
        chk("rb_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rb_ready", 32'(bus.cmd_ready), 32'd1);
        repeat (2) begin
            @(negedge clk);
            chk("rb_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        do_txn(1'b0, 32'h30, 32'h0, 1, 1, rd, er, sc, sw, ok);
        chk("rb_next_done",  32'(ok), 32'd1);
        chk("rb_next_err",   32'(er), 32'd0);
        chk("rb_next_rdata", rd,      ref_mem[12]);

        // Random traffic against the reference memory
        for (int i = 0; i < 40; i++) begin
            w   = 1'($urandom_range(0, 1));
            idx = $urandom_range(0, 63);
            lo  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
            a   = (32'(idx) << 2) | 32'(lo);
            n   = $urandom;
            do_txn(w, a, 32'(n), $urandom_range(0, 2), $urandom_range(0, 3), rd, er, sc, sw, ok);
            chk("rnd_done", 32'(ok), 32'd1);
            if (lo != 0) begin
                chk("rnd_mis_err",   32'(er), 32'd1);
                chk("rnd_mis_rdata", rd,      32'd0);
                chk("rnd_mis_cyc",   32'(sc), 32'd0);
            end else begin
                chk("rnd_err", 32'(er), 32'd0);
                chk("rnd_we",  32'(sw), 32'(w));
                if (w) begin
                    chk("rnd_wr_rdata", rd, 32'd0);
                    ref_mem[idx] = 32'(n);
                end else begin
                    chk("rnd_rd_rdata", rd, ref_mem[idx]);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_classic_initiator.md
Name: wb_classic_initiator

Overview:
- Wishbone-classic bus initiator that drives the same cyc/stb/we/addr/data/ack interface the Memory responder serves.
- Accepts single read/write commands on a valid/ready command port, runs one bus cycle per command, and returns the result on a valid/ready response port.
- Used in verification and bring-up benches to preload, poke and inspect Memory instances without a processor core attached.

Parameters:
- ADDR_WIDTH, 32, width of command and bus address.
- DATA_WIDTH, 32, width of command, response and bus data.
- TIMEOUT_CYCLES, 255, maximum cycles spent waiting for ack; only used with WB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; every register updates on its rising edge.
- rst  input  1  reset: synchronous, active-high.
- cmd_valid  input  1  a command is presented.
- cmd_ready  output  1  block accepts a command this cycle.
- cmd_we  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_WIDTH  byte address.
- cmd_wdata  input  DATA_WIDTH  write data.
- rsp_valid  output  1  a response is presented.
- rsp_ready  input  1  the consumer takes the response.
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and for errors.
- rsp_err  output  1  the transaction failed.
- cyc_o  output  1  Wishbone cycle.
- stb_o  output  1  Wishbone strobe.
- we_o  output  1  Wishbone write enable.
- addr_o  output  ADDR_WIDTH  Wishbone address.
- data_o  output  DATA_WIDTH  Wishbone write data.
- data_i  input  DATA_WIDTH  Wishbone read data.
- ack_i  input  1  Wishbone acknowledge.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- All outputs are registered.
- Reset values: cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, cyc_o=0, stb_o=0, we_o=0, addr_o=0, data_o=0, busy=0.
- States: IDLE, BUS, RESP.
- IDLE, cmd_ready=1:
  - On cmd_valid & cmd_ready with cmd_addr[1:0]==0: latch we, addr and wdata onto we_o/addr_o/data_o; cyc_o=stb_o=1 from the next cycle; go to BUS.
  - On a misaligned address (cmd_addr[1:0]!=0): no bus cycle; go to RESP with rsp_err=1 and rsp_rdata=0.
- BUS, cmd_ready=0: cyc_o, stb_o, we_o, addr_o and data_o are held stable until ack_i is sampled high.
  - On the edge where ack_i=1: cyc_o=stb_o=0, we_o=0; rsp_rdata = we ? 0 : data_i; rsp_err=0; rsp_valid=1; go to RESP.
  - Minimum latency: command accepted at edge N, cyc_o high during cycle N+1, ack sampled at edge N+2 at earliest, rsp_valid high from N+2.
- RESP: rsp_valid, rsp_rdata and rsp_err are held until rsp_ready=1.
  - On that edge: rsp_valid=0; go to IDLE; cmd_ready=1 from the next cycle. There is no back-to-back acceptance in the same cycle.
- ack_i sampled in IDLE or RESP is ignored and causes no state change.
- cmd_valid while cmd_ready=0 is ignored; the command source must hold it.
- rst asserted in any state: on the next edge, all outputs take their reset values, any bus cycle is abandoned (cyc_o drops) and any pending response is discarded.
- busy = (state != IDLE).

Optional Feature:
- Macro: WB_TIMEOUT_EN.
- With WB_TIMEOUT_EN defined:
  - An 8-bit-minimum counter, sized $clog2(TIMEOUT_CYCLES+1), clears on entry to BUS and increments each BUS cycle with ack_i=0.
  - When the counter equals TIMEOUT_CYCLES with ack_i=0: drop cyc_o/stb_o, go to RESP with rsp_err=1 and rsp_rdata=0.
  - If ack_i=1 on the same edge, the ack wins and the transaction completes normally.
- Without WB_TIMEOUT_EN: no counter is built, BUS waits for ack_i indefinitely, and rsp_err is set only by misalignment.

Test Plan:
- Write then read: write addr 0x10 with data 0xDEADBEEF, Memory responder attached → we_o=1 during the write cycle, rsp_err=0. Read addr 0x10 → rsp_rdata=0xDEADBEEF, rsp_err=0.
- Misaligned command: read addr 0x13 → cyc_o never rises, rsp_valid one cycle after acceptance, rsp_err=1, rsp_rdata=0.
- Backpressure: rsp_ready held 0 for 5 cycles after a read of 0x0 → rsp_valid, rsp_rdata and rsp_err stable, cmd_ready=0 throughout; rsp_ready=1 → IDLE, cmd_ready=1 on the next cycle.
- Delayed ack and stray ack: ack delayed 7 cycles → cyc_o/stb_o/addr_o stable for all 7 cycles. A stray ack_i pulse in IDLE → no rsp_valid.
- Reset mid-transaction: rst=1 while in BUS → cyc_o=0 and busy=0 after one edge; no rsp_valid; the next command completes normally.
- Timeout (WB_TIMEOUT_EN, TIMEOUT_CYCLES=4): ack never asserted → rsp_err=1 after 4 waiting cycles. Ack on exactly the 4th waiting cycle → rsp_err=0 with valid data.
